// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with scan-level debounce and a registered one-hot key code.
// Optional KEYPAD_COL_SYNC_EN adds a 2-flop synchroniser on col_n ahead of row sampling.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV       = 1000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  col_n,
   output logic [3:0]  row_n,
   output logic [11:0] key_onehot,
   output logic        key_pressed,
   output logic        key_event
);

   localparam int unsigned   DW         = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [7:0]    DB_MAX     = 8'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_e;

   row_e          row_q, row_d;
   logic [3:0]    row_n_q, row_n_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [8:0]    acc_q, acc_d;
   logic [11:0]   prev_q, prev_d;
   logic [7:0]    stable_q, stable_d;
   logic [11:0]   key_q, key_d;
   logic          pressed_q, pressed_d;
   logic          event_q, event_d;

   logic [2:0]    col_act;
   logic [11:0]   raw_map;
   logic [11:0]   raw;
   logic          sample;
   logic          scan_done;

`ifdef KEYPAD_COL_SYNC_EN
   logic [2:0] sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= col_n;
         sync2_q <= sync1_q;
      end
   end

   assign col_act = ~sync2_q;
`else
   assign col_act = ~col_n;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         row_q     <= ROW0;
         row_n_q   <= 4'b1110;
         dwell_q   <= '0;
         acc_q     <= '0;
         prev_q    <= '0;
         stable_q  <= '0;
         key_q     <= '0;
         pressed_q <= 1'b0;
         event_q   <= 1'b0;
      end else begin
         row_q     <= row_d;
         row_n_q   <= row_n_d;
         dwell_q   <= dwell_d;
         acc_q     <= acc_d;
         prev_q    <= prev_d;
         stable_q  <= stable_d;
         key_q     <= key_d;
         pressed_q <= pressed_d;
         event_q   <= event_d;
      end
   end

   // Row 3 is never stored: its live sample joins the accumulated rows 0-2 on scan completion.
   assign raw_map = {col_act[2], col_act[0], acc_q[8:6], acc_q[5:3], acc_q[2:0], col_act[1]};

   always_comb begin
      sample    = (dwell_q == DWELL_LAST);
      scan_done = sample && (row_q == ROW3);
      dwell_d   = sample ? '0 : dwell_q + 1'b1;
      row_d     = row_q;
      acc_d     = acc_q;
      prev_d    = prev_q;
      stable_d  = stable_q;
      key_d     = key_q;
      pressed_d = pressed_q;
      event_d   = 1'b0;

      if (raw_map != '0 && (raw_map & (raw_map - 12'd1)) == '0) raw = raw_map;
      else                                                      raw = '0;

      if (sample) begin
         unique case (row_q)
            ROW0: begin acc_d[2:0] = col_act; row_d = ROW1; end
            ROW1: begin acc_d[5:3] = col_act; row_d = ROW2; end
            ROW2: begin acc_d[8:6] = col_act; row_d = ROW3; end
            ROW3: begin acc_d      = '0;      row_d = ROW0; end
            default: row_d = ROW0;
         endcase
      end

      if (scan_done) begin
         if (raw == prev_q) begin
            stable_d = (stable_q >= DB_MAX) ? DB_MAX : stable_q + 8'd1;
         end else begin
            stable_d = 8'd1;
            prev_d   = raw;
         end
         if (stable_d == DB_MAX && raw != key_q) begin
            key_d     = raw;
            pressed_d = |raw;
            event_d   = |raw;
         end
      end

      row_n_d = ~(4'b0001 << row_d);
   end

   assign row_n       = row_n_q;
   assign key_onehot  = key_q;
   assign key_pressed = pressed_q;
   assign key_event   = event_q;

endmodule
